// File: rtl/tnkk_select_array_pkg.sv
// -----------------------------------------------------------------------------
// tnkk_select_array_pkg
// Shared definitions for the ternary-weight select stage:
//   - default geometry parameters (channels, kernel edge, widths)
//   - ternary weight-code constants (only the two LSBs of a code are decoded)
// -----------------------------------------------------------------------------
package tnkk_select_array_pkg;

    localparam int TN            = 4;
    localparam int KERNEL_SIZE   = 3;
    localparam int FEATURE_WIDTH = 16;
    localparam int KERNEL_WIDTH  = 2;

    // Ternary weight codes; 2'b10 is reserved and decodes to zero.
    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;

endpackage : tnkk_select_array_pkg

// File: rtl/tnkk_select_array_ternary_select_lane.sv
// -----------------------------------------------------------------------------
// ternary_select_lane
// Combinational per-lane select: passes, negates or zeroes one feature
// according to its ternary weight code.
// Ports:
//   i_feature  [FEATURE_WIDTH-1:0]  signed two's-complement feature
//   i_weight   [KERNEL_WIDTH-1:0]   weight code (only bits [1:0] decoded)
//   o_feature  [FEATURE_WIDTH-1:0]  selected value
// -----------------------------------------------------------------------------
module ternary_select_lane #(
    parameter int FEATURE_WIDTH = tnkk_select_array_pkg::FEATURE_WIDTH,
    parameter int KERNEL_WIDTH  = tnkk_select_array_pkg::KERNEL_WIDTH
) (
    input  logic [FEATURE_WIDTH-1:0] i_feature,
    input  logic [KERNEL_WIDTH-1:0]  i_weight,
    output logic [FEATURE_WIDTH-1:0] o_feature
);
    import tnkk_select_array_pkg::*;

    logic [1:0] w_code;

    assign w_code = i_weight[1:0];

    // Decode the weight code; negation wraps modulo 2^FEATURE_WIDTH, so the
    // most negative value maps onto itself.
    always_comb begin
        o_feature = '0;
        case (w_code)
            W_POS:   o_feature = i_feature;
            W_NEG:   o_feature = (~i_feature) + {{(FEATURE_WIDTH-1){1'b0}}, 1'b1};
            W_ZERO:  o_feature = '0;
            default: o_feature = '0;
        endcase
    end

endmodule : ternary_select_lane

// File: rtl/tnkk_select_array.sv
// -----------------------------------------------------------------------------
// tnkk_select_array
// Ternary-weight multiply stage: Tn channels x KERNEL_SIZE^2 lanes, each lane
// passed, negated or zeroed by its weight; the result is registered with a
// one-cycle latency and a done strobe that is enable delayed by one cycle.
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   feature_in        packed feature lanes, lane j at [(j+1)*FW-1 : j*FW]
//   weight_in         packed weight codes, lane j at [(j+1)*KW-1 : j*KW]
//   enable            inputs valid this cycle
//   feature_out       registered selected lanes (held while enable=0)
//   ternary_com_done  output valid strobe
// -----------------------------------------------------------------------------
module tnkk_select_array #(
    parameter int Tn            = tnkk_select_array_pkg::TN,
    parameter int KERNEL_SIZE   = tnkk_select_array_pkg::KERNEL_SIZE,
    parameter int FEATURE_WIDTH = tnkk_select_array_pkg::FEATURE_WIDTH,
    parameter int KERNEL_WIDTH  = tnkk_select_array_pkg::KERNEL_WIDTH
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [Tn*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] feature_in,
    input  logic [Tn*KERNEL_SIZE*KERNEL_SIZE*KERNEL_WIDTH-1:0]  weight_in,
    input  logic                                               enable,
    output logic [Tn*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] feature_out,
    output logic                                               ternary_com_done
);
    localparam int N_LANES = Tn * KERNEL_SIZE * KERNEL_SIZE;
    localparam int F_BITS  = N_LANES * FEATURE_WIDTH;

    // A weight code narrower than two bits cannot express the ternary set.
    if (KERNEL_WIDTH < 2) begin : g_bad_kernel_width
        $error("tnkk_select_array: KERNEL_WIDTH must be >= 2");
    end

    logic [F_BITS-1:0] w_sel;
    logic [F_BITS-1:0] r_feature_out;
    logic              r_done;

    for (genvar j = 0; j < N_LANES; j++) begin : g_lane
        ternary_select_lane #(
            .FEATURE_WIDTH (FEATURE_WIDTH),
            .KERNEL_WIDTH  (KERNEL_WIDTH)
        ) u_lane (
            .i_feature (feature_in[j*FEATURE_WIDTH +: FEATURE_WIDTH]),
            .i_weight  (weight_in[j*KERNEL_WIDTH +: KERNEL_WIDTH]),
            .o_feature (w_sel[j*FEATURE_WIDTH +: FEATURE_WIDTH])
        );
    end

    // Output register: capture selected lanes on enable, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_feature_out <= '0;
            r_done        <= 1'b0;
        end else if (enable) begin
            r_feature_out <= w_sel;
            r_done        <= 1'b1;
        end else begin
            r_feature_out <= r_feature_out;
            r_done        <= 1'b0;
        end
    end

    assign feature_out      = r_feature_out;
    assign ternary_com_done = r_done;

endmodule : tnkk_select_array

// File: tb/tb_tnkk_select_array.sv
// Self-checking bench for tnkk_select_array: directed vector table, hand-written
// reset/hold/streaming sequences and a randomized run against a lane model.
module tb_tnkk_select_array;
    localparam int TN = 4;
    localparam int KS = 3;
    localparam int FW = 16;
    localparam int KW = 2;
    localparam int N  = TN * KS * KS;
    localparam int FB = N * FW;
    localparam int WB = N * KW;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [FB-1:0] feature_in;
    logic [WB-1:0] weight_in;
    logic [FB-1:0] feature_out;
    logic          ternary_com_done;

    int vectors     = 0;
    int miscompares = 0;

    tnkk_select_array #(
        .Tn            (TN),
        .KERNEL_SIZE   (KS),
        .FEATURE_WIDTH (FW),
        .KERNEL_WIDTH  (KW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .feature_in       (feature_in),
        .weight_in        (weight_in),
        .enable           (enable),
        .feature_out      (feature_out),
        .ternary_com_done (ternary_com_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [FB-1:0] f;
        logic [WB-1:0] w;
        logic [FB-1:0] e;
    } vec_t;

    vec_t tbl[5];

    // Reference: lane value as an integer 0..2^FW-1, selected by weight mod 4.
    function automatic logic [FW-1:0] ref_lane(input logic [FW-1:0] x, input logic [KW-1:0] w);
        int xi;
        int r;
        int code;
        xi   = int'(x);
        code = int'(w) % 4;
        if (code == 1)      r = xi;
        else if (code == 3) r = (65536 - xi) % 65536;
        else                r = 0;
        return r[FW-1:0];
    endfunction

    function automatic logic [FB-1:0] ref_all(input logic [FB-1:0] f, input logic [WB-1:0] w);
        logic [FB-1:0] o;
        o = '0;
        for (int j = 0; j < N; j++) o[j*FW +: FW] = ref_lane(f[j*FW +: FW], w[j*KW +: KW]);
        return o;
    endfunction

    function automatic logic [FB-1:0] setf(input logic [FB-1:0] v, input int j, input logic [FW-1:0] x);
        logic [FB-1:0] o;
        o = v;
        o[j*FW +: FW] = x;
        return o;
    endfunction

    function automatic logic [WB-1:0] setw(input logic [WB-1:0] v, input int j, input logic [KW-1:0] x);
        logic [WB-1:0] o;
        o = v;
        o[j*KW +: KW] = x;
        return o;
    endfunction

    task automatic chk_vec(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(output logic [FB-1:0] f, output logic [WB-1:0] w);
        logic [FW-1:0] x;
        for (int j = 0; j < N; j++) begin
            case ($urandom_range(0, 7))
                0: x = 16'h8000;
                1: x = 16'h7FFF;
                2: x = 16'hFFFF;
                3: x = 16'h0000;
                default: x = FW'($urandom);
            endcase
            f[j*FW +: FW] = x;
            w[j*KW +: KW] = KW'($urandom);
        end
    endtask

    logic [FB-1:0] exp_out;
    logic          exp_done;
    logic [FB-1:0] rf;
    logic [WB-1:0] rw;

    initial begin
        // ---------------- directed table ----------------
        tbl[0].name = "mixed";
        tbl[0].f = '0; tbl[0].w = '0; tbl[0].e = '0;
        tbl[0].f = setf(tbl[0].f, 0, 16'd100);  tbl[0].w = setw(tbl[0].w, 0, 2'b01); tbl[0].e = setf(tbl[0].e, 0, 16'd100);
        tbl[0].f = setf(tbl[0].f, 1, 16'd100);  tbl[0].w = setw(tbl[0].w, 1, 2'b11); tbl[0].e = setf(tbl[0].e, 1, 16'hFF9C);
        tbl[0].f = setf(tbl[0].f, 2, 16'hFFF9); tbl[0].w = setw(tbl[0].w, 2, 2'b11); tbl[0].e = setf(tbl[0].e, 2, 16'd7);
        tbl[0].f = setf(tbl[0].f, 3, 16'd1234); tbl[0].w = setw(tbl[0].w, 3, 2'b00);
        tbl[0].f = setf(tbl[0].f, 4, 16'd55);   tbl[0].w = setw(tbl[0].w, 4, 2'b10);

        tbl[1].name = "boundary";
        tbl[1].f = '0; tbl[1].w = '0; tbl[1].e = '0;
        tbl[1].f = setf(tbl[1].f, 0, 16'h8000); tbl[1].w = setw(tbl[1].w, 0, 2'b11); tbl[1].e = setf(tbl[1].e, 0, 16'h8000);
        tbl[1].f = setf(tbl[1].f, 1, 16'h7FFF); tbl[1].w = setw(tbl[1].w, 1, 2'b11); tbl[1].e = setf(tbl[1].e, 1, 16'h8001);
        tbl[1].f = setf(tbl[1].f, 2, 16'hFFFF); tbl[1].w = setw(tbl[1].w, 2, 2'b01); tbl[1].e = setf(tbl[1].e, 2, 16'hFFFF);
        tbl[1].f = setf(tbl[1].f, 3, 16'h0000); tbl[1].w = setw(tbl[1].w, 3, 2'b11);
        tbl[1].f = setf(tbl[1].f, 4, 16'h0001); tbl[1].w = setw(tbl[1].w, 4, 2'b11); tbl[1].e = setf(tbl[1].e, 4, 16'hFFFF);

        tbl[2].name = "lane_map_pos";
        tbl[3].name = "lane_map_neg";
        tbl[4].name = "reserved_all";
        tbl[2].f = '0; tbl[2].w = '0; tbl[2].e = '0;
        tbl[3].f = '0; tbl[3].w = '0; tbl[3].e = '0;
        tbl[4].f = '0; tbl[4].w = '0; tbl[4].e = '0;
        for (int j = 0; j < N; j++) begin
            tbl[2].f = setf(tbl[2].f, j, FW'(j + 1));
            tbl[2].w = setw(tbl[2].w, j, 2'b01);
            tbl[2].e = setf(tbl[2].e, j, FW'(j + 1));
            tbl[3].f = setf(tbl[3].f, j, FW'(j + 1));
            tbl[3].w = setw(tbl[3].w, j, 2'b11);
            tbl[3].e = setf(tbl[3].e, j, FW'(65536 - (j + 1)));
            tbl[4].f = setf(tbl[4].f, j, 16'hAAAA);
            tbl[4].w = setw(tbl[4].w, j, 2'b10);
        end

        // ---------------- reset with enable held high ----------------
        rst = 1'b1; enable = 1'b1; feature_in = tbl[2].f; weight_in = tbl[2].w;
        step();
        chk_vec("reset_out_c1", feature_out, '0);
        chk_bit("reset_done_c1", ternary_com_done, 1'b0);
        step();
        chk_vec("reset_out_c2", feature_out, '0);
        chk_bit("reset_done_c2", ternary_com_done, 1'b0);
        rst = 1'b0; enable = 1'b0;
        step();
        chk_vec("idle_out", feature_out, '0);
        chk_bit("idle_done", ternary_com_done, 1'b0);

        // ---------------- table ----------------
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1; feature_in = tbl[i].f; weight_in = tbl[i].w;
            step();
            chk_vec(tbl[i].name, feature_out, tbl[i].e);
            chk_bit({tbl[i].name, "_done"}, ternary_com_done, 1'b1);
        end
        // top lane position check
        enable = 1'b1; feature_in = tbl[2].f; weight_in = tbl[2].w;
        step();
        chk_vec("top_lane", {{(FB-FW){1'b0}}, feature_out[575:560]}, {{(FB-FW){1'b0}}, 16'd36});

        // ---------------- hold ----------------
        enable = 1'b0; step();
        enable = 1'b1; feature_in = tbl[0].f; weight_in = tbl[0].w;
        step();
        chk_vec("hold_capture", feature_out, tbl[0].e);
        chk_bit("hold_done_hi", ternary_com_done, 1'b1);
        enable = 1'b0; feature_in = tbl[3].f; weight_in = tbl[3].w;
        step();
        chk_vec("hold_keep1", feature_out, tbl[0].e);
        chk_bit("hold_done_lo1", ternary_com_done, 1'b0);
        step();
        chk_vec("hold_keep2", feature_out, tbl[0].e);
        chk_bit("hold_done_lo2", ternary_com_done, 1'b0);

        // ---------------- streaming then mid-stream reset ----------------
        for (int i = 0; i < 5; i++) begin
            rand_inputs(rf, rw);
            enable = 1'b1; feature_in = rf; weight_in = rw;
            step();
            chk_vec("stream_out", feature_out, ref_all(rf, rw));
            chk_bit("stream_done", ternary_com_done, 1'b1);
        end
        rand_inputs(rf, rw);
        rst = 1'b1; feature_in = rf; weight_in = rw;
        step();
        chk_vec("stream_rst_out", feature_out, '0);
        chk_bit("stream_rst_done", ternary_com_done, 1'b0);
        rst = 1'b0; enable = 1'b0;
        step();
        chk_bit("post_rst_idle", ternary_com_done, 1'b0);
        enable = 1'b1;
        step();
        chk_bit("post_rst_first", ternary_com_done, 1'b1);
        chk_vec("post_rst_first_out", feature_out, ref_all(rf, rw));

        // ---------------- randomized run ----------------
        exp_out = feature_out;
        for (int c = 0; c < 400; c++) begin
            rand_inputs(rf, rw);
            rst        = ($urandom_range(0, 31) == 0);
            enable     = ($urandom_range(0, 3) != 0);
            feature_in = rf;
            weight_in  = rw;
            if (rst) begin
                exp_out  = '0;
                exp_done = 1'b0;
            end else begin
                if (enable) exp_out = ref_all(rf, rw);
                exp_done = enable;
            end
            step();
            chk_vec("rand_out", feature_out, exp_out);
            chk_bit("rand_done", ternary_com_done, exp_done);
        end

        rst = 1'b0; enable = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_tnkk_select_array
